core_dispatch_scoreboard: RTL and testbench
===========================================

# core_dispatch_scoreboard

Pending-write tracker for the dual-issue dispatch stage. It records the destination register of every instruction that dispatch sends to an execution unit, and keeps one 16-bit pending mask per unit (ALU A, ALU B, branch, ld/st, mul). Each unit's bit clears when that unit signals writeback completion. Its masks, together with the one-hot source masks it decodes, are the inputs the dispatch hazard check consumes. It sits between decode/dispatch and the execution-unit writeback ports.

## Interface
- Parameters: none.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- cur_a, cur_b  in  insn_decode  instructions in dispatch slots A and B
- dispatch_a, dispatch_b  in  1  dispatch decision for slots A and B this cycle
- flush  in  1  squash of younger, not yet completed work
- done_{alu_a,alu_b,branch,ldst,mul}  in  1  writeback completion pulse, one per unit
- done_{alu_a,alu_b,branch,ldst,mul}_rd  in  reg_num  register written by that completion
- mask_a_ra, mask_a_rb, mask_b_ra, mask_b_rb  out  hword  one-hot source masks; all-zero when the corresponding uses_ra/uses_rb is clear
- mask_{alu_a,alu_b,branch,ldst,mul}  out  hword  pending-write mask per unit
- busy_{alu_a,alu_b,branch,ldst,mul}  out  1  unit has one instruction in flight
- sb_error  out  1  sticky protocol-violation flag

## Operation
- Unit selection for a dispatched slot: branch if ctrl.branch, else ldst if ctrl.ldst, else mul if ctrl.mul, else ALU A for slot A / ALU B for slot B.
- Only slots with ctrl.execute and data.writeback set a mask bit. Other dispatched instructions still set busy and must complete.
- Dispatch with writeback: bit data.rd of the selected unit's mask is set, and that unit's busy is set.
- Each unit holds at most one in-flight instruction, so each mask has at most one bit set.
- done_X: clears mask_X and busy_X.
- done_X and a new dispatch to X in the same cycle: the new instruction wins; mask_X becomes one-hot of the new rd and busy stays set.
- The same rd pending in two different units (WAW) is legal. Each unit clears only its own mask.
- flush: clears mask and busy of alu_a, alu_b and branch. ldst and mul are never squashed and clear only on their own done.
- Dispatches in a flush cycle are ignored.
- sb_error is set, and held until rst, on any of:
  - done_X with busy_X clear;
  - dispatch to X while busy_X is set and done_X is low;
  - done_X_rd differing from the recorded rd while mask_X is non-zero;
  - slots A and B selecting the same non-ALU unit in one cycle.
- Source masks are purely combinational decodes of cur_a/cur_b ra/rb.

## Timing
- Reset: all masks 0, all busy 0, sb_error 0.
- A set from dispatch in cycle N is visible on the outputs in cycle N+1.
- A clear from done or flush in cycle N is visible in N+1 by default. See Configuration.
- Source masks have zero latency.
- No handshake backpressure: done pulses are single-cycle and are always accepted.
- rst mid-operation abandons all tracking. Units must also be reset in the same cycle.

## Configuration
- CORE_SCOREBOARD_BYPASS_EN defined: each output mask is gated combinationally, mask_X = reg_X & ~(done_X ? onehot(done_X_rd) : 0). A register therefore releases in the completion cycle, saving one dispatch bubble. busy_X is gated the same way. A same-cycle redispatch to X still shows the new bit only from N+1.
- Not defined: outputs come straight from the registers, giving a one-cycle release latency.

## Structure
- Shared package (core/uarch.sv): hword, reg_num, insn_decode, plus a new enum exec_unit {EU_ALU_A, EU_ALU_B, EU_BRANCH, EU_LDST, EU_MUL} and NUM_EXEC_UNITS = 5.
- Sub-module core_dispatch_scoreboard_unit, instantiated 5 times. Each instance owns: a mask register, busy, the recorded rd, a flushable flag, the bypass gating, and local error detection.
- Top level holds slot-to-unit steering, the source decode, and the sb_error OR/sticky register.

## Test plan
- Slot A ALU rd=r3 dispatched in cycle 0 → mask_alu_a=0x0008 in cycle 1; done_alu_a rd=3 in cycle 4 → 0x0000 in cycle 5, or already in cycle 4 with bypass.
- ldst rd=r7 and mul rd=r7 both pending, then flush → ldst=0x0080 and mul=0x0080 stay; done_ldst → only mask_mul=0x0080 remains.
- done_alu_b rd=2 and dispatch slot B ALU rd=9 in the same cycle → mask_alu_b=0x0200, busy_alu_b=1, sb_error=0.
- done_mul with busy_mul=0 → sb_error=1 next cycle, held until rst; rst → all outputs 0.
- cur_a ra=r1 uses_rb=0 → mask_a_ra=0x0002, mask_a_rb=0x0000 in the same cycle.
- Branch dispatched with writeback=0 → mask_branch stays 0 and busy_branch=1; flush → busy_branch=0.

Source files
------------

// File: rtl/core_dispatch_scoreboard_pkg.sv
// core_dispatch_scoreboard_pkg: shared decode types, execution-unit enum and helpers for the pending-write scoreboard.
package core_dispatch_scoreboard_pkg;
  typedef logic [15:0] hword;
  typedef logic [3:0] reg_num;
  typedef struct packed {
    logic execute;
    logic branch;
    logic ldst;
    logic mul;
  } insn_ctrl;
  typedef struct packed {
    reg_num rd;
    reg_num ra;
    reg_num rb;
    logic uses_ra;
    logic uses_rb;
    logic writeback;
  } insn_data;
  typedef struct packed {
    insn_ctrl ctrl;
    insn_data data;
  } insn_decode;
  typedef enum logic [2:0] {EU_ALU_A, EU_ALU_B, EU_BRANCH, EU_LDST, EU_MUL} exec_unit;
  localparam int NUM_EXEC_UNITS = 5;
  function automatic hword onehot(reg_num r);
    return hword'(1) << r;
  endfunction
  function automatic exec_unit steer(insn_ctrl c, logic slot_b);
    return c.branch ? EU_BRANCH : c.ldst ? EU_LDST : c.mul ? EU_MUL : slot_b ? EU_ALU_B : EU_ALU_A;
  endfunction
endpackage

// File: rtl/core_dispatch_scoreboard_if.sv
// core_dispatch_scoreboard_if: dispatch, writeback and hazard-mask signals between dispatch and the scoreboard.
interface core_dispatch_scoreboard_if;
  import core_dispatch_scoreboard_pkg::*;
  insn_decode cur_a, cur_b;
  logic dispatch_a, dispatch_b, flush;
  logic done_alu_a, done_alu_b, done_branch, done_ldst, done_mul;
  reg_num done_alu_a_rd, done_alu_b_rd, done_branch_rd, done_ldst_rd, done_mul_rd;
  hword mask_a_ra, mask_a_rb, mask_b_ra, mask_b_rb;
  hword mask_alu_a, mask_alu_b, mask_branch, mask_ldst, mask_mul;
  logic busy_alu_a, busy_alu_b, busy_branch, busy_ldst, busy_mul;
  logic sb_error;
  modport master (
    output cur_a, cur_b, dispatch_a, dispatch_b, flush,
    output done_alu_a, done_alu_b, done_branch, done_ldst, done_mul,
    output done_alu_a_rd, done_alu_b_rd, done_branch_rd, done_ldst_rd, done_mul_rd,
    input mask_a_ra, mask_a_rb, mask_b_ra, mask_b_rb,
    input mask_alu_a, mask_alu_b, mask_branch, mask_ldst, mask_mul,
    input busy_alu_a, busy_alu_b, busy_branch, busy_ldst, busy_mul, sb_error
  );
  modport slave (
    input cur_a, cur_b, dispatch_a, dispatch_b, flush,
    input done_alu_a, done_alu_b, done_branch, done_ldst, done_mul,
    input done_alu_a_rd, done_alu_b_rd, done_branch_rd, done_ldst_rd, done_mul_rd,
    output mask_a_ra, mask_a_rb, mask_b_ra, mask_b_rb,
    output mask_alu_a, mask_alu_b, mask_branch, mask_ldst, mask_mul,
    output busy_alu_a, busy_alu_b, busy_branch, busy_ldst, busy_mul, sb_error
  );
endinterface

// File: rtl/core_dispatch_scoreboard_unit.sv
// core_dispatch_scoreboard_unit: one execution unit's pending-write slot with local error detection.
// CORE_SCOREBOARD_BYPASS_EN releases the mask/busy combinationally in the completion cycle.
module core_dispatch_scoreboard_unit
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter bit FLUSHABLE = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   disp,
  input  logic   disp_wb,
  input  reg_num disp_rd,
  input  logic   done,
  input  reg_num done_rd,
  input  logic   flush,
  output hword   mask,
  output logic   busy,
  output logic   err
);
  hword mask_q, mask_d;
  logic busy_q, busy_d;
  reg_num rd_q, rd_d;
  logic clr;
  always_comb begin
    clr = done | (flush & FLUSHABLE);
    busy_d = disp | (busy_q & ~clr);
    mask_d = disp ? (disp_wb ? onehot(disp_rd) : '0) : clr ? '0 : mask_q;
    rd_d = disp ? disp_rd : rd_q;
    err = (done & ~busy_q) | (disp & busy_q & ~done) | (done & (|mask_q) & (done_rd != rd_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      busy_q <= 1'b0;
      rd_q <= '0;
    end else begin
      mask_q <= mask_d;
      busy_q <= busy_d;
      rd_q <= rd_d;
    end
  end
`ifdef CORE_SCOREBOARD_BYPASS_EN
  assign mask = mask_q & ~(done ? onehot(done_rd) : '0);
  assign busy = busy_q & ~done;
`else
  assign mask = mask_q;
  assign busy = busy_q;
`endif
endmodule

// File: rtl/core_dispatch_scoreboard.sv
// core_dispatch_scoreboard: per-unit pending-write tracker and source-mask decode for the dual-issue dispatch hazard check.
// CORE_SCOREBOARD_BYPASS_EN (in the unit) makes completions visible in the same cycle.
module core_dispatch_scoreboard
  import core_dispatch_scoreboard_pkg::*;
(
  input logic clk,
  input logic rst,
  core_dispatch_scoreboard_if.slave sb
);
  exec_unit sel_a, sel_b;
  logic conflict, sb_error_q, sb_error_d;
  logic [NUM_EXEC_UNITS-1:0] done, busy, err;
  reg_num done_rd [NUM_EXEC_UNITS];
  hword mask [NUM_EXEC_UNITS];
  assign done = {sb.done_mul, sb.done_ldst, sb.done_branch, sb.done_alu_b, sb.done_alu_a};
  assign done_rd = '{sb.done_alu_a_rd, sb.done_alu_b_rd, sb.done_branch_rd, sb.done_ldst_rd, sb.done_mul_rd};
  always_comb begin
    sel_a = steer(sb.cur_a.ctrl, 1'b0);
    sel_b = steer(sb.cur_b.ctrl, 1'b1);
    // ALU slots steer to distinct units, so equality can only mean a shared non-ALU unit
    conflict = sb.dispatch_a & sb.dispatch_b & ~sb.flush & (sel_a == sel_b);
    sb_error_d = sb_error_q | conflict | (|err);
  end
  for (genvar i = 0; i < NUM_EXEC_UNITS; i++) begin : g_unit
    logic a_hit, b_hit;
    assign a_hit = sb.dispatch_a & (sel_a == exec_unit'(i));
    assign b_hit = sb.dispatch_b & (sel_b == exec_unit'(i));
    core_dispatch_scoreboard_unit #(.FLUSHABLE(i < int'(EU_LDST))) u_unit (
      .clk(clk),
      .rst(rst),
      .disp((a_hit | b_hit) & ~sb.flush),
      .disp_wb(a_hit ? sb.cur_a.ctrl.execute & sb.cur_a.data.writeback
                     : sb.cur_b.ctrl.execute & sb.cur_b.data.writeback),
      .disp_rd(a_hit ? sb.cur_a.data.rd : sb.cur_b.data.rd),
      .done(done[i]),
      .done_rd(done_rd[i]),
      .flush(sb.flush),
      .mask(mask[i]),
      .busy(busy[i]),
      .err(err[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) sb_error_q <= 1'b0;
    else sb_error_q <= sb_error_d;
  end
  assign sb.mask_a_ra = sb.cur_a.data.uses_ra ? onehot(sb.cur_a.data.ra) : '0;
  assign sb.mask_a_rb = sb.cur_a.data.uses_rb ? onehot(sb.cur_a.data.rb) : '0;
  assign sb.mask_b_ra = sb.cur_b.data.uses_ra ? onehot(sb.cur_b.data.ra) : '0;
  assign sb.mask_b_rb = sb.cur_b.data.uses_rb ? onehot(sb.cur_b.data.rb) : '0;
  assign sb.mask_alu_a = mask[EU_ALU_A];
  assign sb.mask_alu_b = mask[EU_ALU_B];
  assign sb.mask_branch = mask[EU_BRANCH];
  assign sb.mask_ldst = mask[EU_LDST];
  assign sb.mask_mul = mask[EU_MUL];
  assign sb.busy_alu_a = busy[EU_ALU_A];
  assign sb.busy_alu_b = busy[EU_ALU_B];
  assign sb.busy_branch = busy[EU_BRANCH];
  assign sb.busy_ldst = busy[EU_LDST];
  assign sb.busy_mul = busy[EU_MUL];
  assign sb.sb_error = sb_error_q;
endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
// tb_core_dispatch_scoreboard: directed test-plan steps plus randomized traffic against a pending-instruction model.
module tb_core_dispatch_scoreboard;
  import core_dispatch_scoreboard_pkg::*;
`ifdef CORE_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  core_dispatch_scoreboard_if sb();
  core_dispatch_scoreboard dut (.clk(clk), .rst(rst), .sb(sb));

  insn_decode a, b;
  logic da, db, fl;
  logic [4:0] dn;
  logic [3:0] dn_rd [5];
  // model: one record per unit of the instruction it holds
  bit m_busy [5];
  bit m_wb [5];
  logic [3:0] m_rd [5];
  bit m_err;
  int passed = 0;
  int total = 0;

  function automatic insn_decode mk(bit ex, bit br, bit ls, bit mu, bit wb, logic [3:0] rd);
    insn_decode i;
    i = '0;
    i.ctrl.execute = ex;
    i.ctrl.branch = br;
    i.ctrl.ldst = ls;
    i.ctrl.mul = mu;
    i.data.writeback = wb;
    i.data.rd = rd;
    return i;
  endfunction

  function automatic int unit_of(insn_decode i, bit slot_b);
    if (i.ctrl.branch) return 2;
    if (i.ctrl.ldst) return 3;
    if (i.ctrl.mul) return 4;
    return slot_b ? 1 : 0;
  endfunction

  function automatic logic [15:0] bit_of(logic [3:0] r);
    logic [15:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic idle();
    a = '0; b = '0; da = 0; db = 0; fl = 0; dn = '0;
    for (int u = 0; u < 5; u++) dn_rd[u] = '0;
  endtask

  task automatic apply();
    sb.cur_a = a; sb.cur_b = b; sb.dispatch_a = da; sb.dispatch_b = db; sb.flush = fl;
    sb.done_alu_a = dn[0]; sb.done_alu_b = dn[1]; sb.done_branch = dn[2];
    sb.done_ldst = dn[3]; sb.done_mul = dn[4];
    sb.done_alu_a_rd = dn_rd[0]; sb.done_alu_b_rd = dn_rd[1]; sb.done_branch_rd = dn_rd[2];
    sb.done_ldst_rd = dn_rd[3]; sb.done_mul_rd = dn_rd[4];
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [15:0] mo [5];
    logic bo [5];
    logic [15:0] me;
    logic be;
    mo = '{sb.mask_alu_a, sb.mask_alu_b, sb.mask_branch, sb.mask_ldst, sb.mask_mul};
    bo = '{sb.busy_alu_a, sb.busy_alu_b, sb.busy_branch, sb.busy_ldst, sb.busy_mul};
    for (int u = 0; u < 5; u++) begin
      me = (m_busy[u] && m_wb[u]) ? bit_of(m_rd[u]) : 16'h0;
      be = m_busy[u];
      if (BYP && dn[u]) begin
        me = me & ~bit_of(dn_rd[u]);
        be = 1'b0;
      end
      chk($sformatf("mask_u%0d", u), mo[u], me);
      chk($sformatf("busy_u%0d", u), {15'h0, bo[u]}, {15'h0, be});
    end
    chk("mask_a_ra", sb.mask_a_ra, a.data.uses_ra ? bit_of(a.data.ra) : 16'h0);
    chk("mask_a_rb", sb.mask_a_rb, a.data.uses_rb ? bit_of(a.data.rb) : 16'h0);
    chk("mask_b_ra", sb.mask_b_ra, b.data.uses_ra ? bit_of(b.data.ra) : 16'h0);
    chk("mask_b_rb", sb.mask_b_rb, b.data.uses_rb ? bit_of(b.data.rb) : 16'h0);
    chk("sb_error", {15'h0, sb.sb_error}, {15'h0, m_err});
  endtask

  task automatic install(int u, insn_decode i);
    m_busy[u] = 1;
    m_wb[u] = i.ctrl.execute && i.data.writeback;
    m_rd[u] = i.data.rd;
  endtask

  task automatic step();
    int ua, ub;
    bit nerr;
    bit dsp [5];
    @(posedge clk);
    if (rst) begin
      for (int u = 0; u < 5; u++) begin m_busy[u] = 0; m_wb[u] = 0; m_rd[u] = '0; end
      m_err = 0;
    end else begin
      nerr = 0;
      ua = unit_of(a, 0);
      ub = unit_of(b, 1);
      for (int u = 0; u < 5; u++) dsp[u] = 0;
      if (!fl) begin
        if (da) dsp[ua] = 1;
        if (db) dsp[ub] = 1;
        if (da && db && ua == ub) nerr = 1;
      end
      for (int u = 0; u < 5; u++) begin
        if (dn[u] && !m_busy[u]) nerr = 1;
        if (dn[u] && m_busy[u] && m_wb[u] && dn_rd[u] != m_rd[u]) nerr = 1;
        if (dsp[u] && m_busy[u] && !dn[u]) nerr = 1;
        if (dn[u] || (fl && u < 3)) begin m_busy[u] = 0; m_wb[u] = 0; end
      end
      if (!fl) begin
        if (db) install(ub, b);
        if (da) install(ua, a);
      end
      m_err = m_err | nerr;
    end
    @(negedge clk);
  endtask

  task automatic peek();
    apply();
    #1;
    check_all();
  endtask

  task automatic cycle();
    peek();
    step();
  endtask

  initial begin
    rst = 1;
    idle();
    apply();
    step();
    cycle();
    rst = 0;
    // slot A ALU r3, completed four cycles later
    idle(); a = mk(1, 0, 0, 0, 1, 3); da = 1; cycle();
    idle(); peek(); chk("tp1_set", sb.mask_alu_a, 16'h0008); step();
    cycle(); cycle();
    dn[0] = 1; dn_rd[0] = 3; peek(); chk("tp1_done_cycle", sb.mask_alu_a, BYP ? 16'h0 : 16'h0008); step();
    idle(); peek(); chk("tp1_cleared", sb.mask_alu_a, 16'h0); step();
    // WAW on r7 across ldst and mul survives a flush
    a = mk(1, 0, 1, 0, 1, 7); b = mk(1, 0, 0, 1, 1, 7); da = 1; db = 1; cycle();
    idle(); fl = 1; cycle();
    idle(); peek(); chk("tp2_ldst", sb.mask_ldst, 16'h0080); chk("tp2_mul", sb.mask_mul, 16'h0080); step();
    dn[3] = 1; dn_rd[3] = 7; cycle();
    idle(); peek(); chk("tp2_ldst_done", sb.mask_ldst, 16'h0); chk("tp2_mul_kept", sb.mask_mul, 16'h0080); step();
    dn[4] = 1; dn_rd[4] = 7; cycle();
    // completion and redispatch to alu_b in the same cycle
    idle(); b = mk(1, 0, 0, 0, 1, 2); db = 1; cycle();
    idle(); dn[1] = 1; dn_rd[1] = 2; b = mk(1, 0, 0, 0, 1, 9); db = 1; cycle();
    idle(); peek();
    chk("tp3_mask", sb.mask_alu_b, 16'h0200);
    chk("tp3_busy", {15'h0, sb.busy_alu_b}, 16'h1);
    chk("tp3_err", {15'h0, sb.sb_error}, 16'h0);
    step();
    dn[1] = 1; dn_rd[1] = 9; cycle();
    // branch without writeback, then flushed
    idle(); a = mk(1, 1, 0, 0, 0, 5); da = 1; cycle();
    idle(); peek(); chk("tp6_mask", sb.mask_branch, 16'h0); chk("tp6_busy", {15'h0, sb.busy_branch}, 16'h1); step();
    fl = 1; cycle();
    idle(); peek(); chk("tp6_flushed", {15'h0, sb.busy_branch}, 16'h0); step();
    // source decode is combinational
    a.data.ra = 1; a.data.uses_ra = 1; a.data.rb = 5; a.data.uses_rb = 0;
    peek(); chk("tp5_ra", sb.mask_a_ra, 16'h0002); chk("tp5_rb", sb.mask_a_rb, 16'h0); step();
    // spurious completion latches the error until reset
    idle(); dn[4] = 1; dn_rd[4] = 4; cycle();
    idle(); peek(); chk("tp4_err", {15'h0, sb.sb_error}, 16'h1); step();
    cycle(); cycle();
    a = mk(1, 0, 1, 0, 1, 12); da = 1; cycle();
    idle(); rst = 1; cycle();
    rst = 0; peek(); chk("tp4_rst_err", {15'h0, sb.sb_error}, 16'h0); chk("tp4_rst_ldst", sb.mask_ldst, 16'h0); step();
    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      a = insn_decode'($urandom);
      b = insn_decode'($urandom);
      a.ctrl.branch = ($urandom_range(0, 4) == 0); a.ctrl.ldst = ($urandom_range(0, 4) == 0); a.ctrl.mul = ($urandom_range(0, 4) == 0);
      b.ctrl.branch = ($urandom_range(0, 4) == 0); b.ctrl.ldst = ($urandom_range(0, 4) == 0); b.ctrl.mul = ($urandom_range(0, 4) == 0);
      da = ($urandom_range(0, 2) == 0);
      db = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 11) == 0);
      for (int u = 0; u < 5; u++) begin
        dn_rd[u] = 4'($urandom_range(0, 15));
        if (m_busy[u] && $urandom_range(0, 2) == 0) begin
          dn[u] = 1;
          if ($urandom_range(0, 9) != 0) dn_rd[u] = m_rd[u];
        end else dn[u] = ($urandom_range(0, 39) == 0);
      end
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
